fifo_serial_tx: RTL and testbench

- Read-side consumer for the team's synchronous FIFO.
- Watches the FIFO empty flag and pops one word at a time with a single-cycle read-enable pulse.
- Serialises each word onto a single UART-style line: start bit, data LSB first, optional even parity, stop bit(s).
- Sits between the FIFO read port and the chip output pin, so FIFO-buffered nibbles can leave the design serially.

---
 rtl/fifo_serial_tx.sv | 176 +++++++++++++++++
 tb/tb_fifo_serial_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Read-side consumer for the synchronous FIFO. It waits for a non-empty
//   FIFO and pops one word with a single-cycle read strobe. It then
//   serialises the word onto a UART-style line: start bit, data LSB first,
//   optional even parity, then one or two stop bits.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   tx_enable    permission to start new frames (sampled in IDLE / end of STOP)
//   fifo_empty   FIFO empty flag
//   fifo_rd_data FIFO read data, valid one cycle after fifo_rd_ena
//   fifo_rd_ena  FIFO read strobe, one-cycle registered pulse
//   tx           serial line, idle high, registered
//   busy         high whenever the controller is not in IDLE
//   frame_done   one-cycle pulse on the last cycle of the final stop bit
module fifo_serial_tx #(
  parameter int FIFO_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_ena,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(FIFO_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_PENULT = DIV_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(FIFO_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state;
  logic [DIV_W-1:0]        div;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FIFO_WIDTH-1:0]   shift;
  logic                    parity;

  logic                    start_ok;
  logic                    div_wrap;
  logic [FIFO_WIDTH-1:0]   shift_nxt;

  assign start_ok  = tx_enable && !fifo_empty;
  assign div_wrap  = (div == DIV_LAST);
  assign shift_nxt = shift >> 1;

  // Outputs are registered: each transition also loads the line value,
  // strobe and flags that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tx          <= 1'b1;
      fifo_rd_ena <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      div         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
    end else begin
      fifo_rd_ena <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (start_ok) begin
            state       <= S_POP;
            fifo_rd_ena <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_POP: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          // Read data arrives one cycle after the strobe, i.e. now.
          shift  <= fifo_rd_data;
          parity <= ^fifo_rd_data;
          div    <= '0;
          tx     <= 1'b0;
          state  <= S_START;
        end
        S_START: begin
          if (div_wrap) begin
            div     <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            div <= div + 1'b1;
          end
        end
        S_DATA: begin
          if (div_wrap) begin
            div <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift_nxt;
              tx      <= shift_nxt[0];
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_PARITY: begin
          if (div_wrap) begin
            div     <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= S_STOP;
          end else begin
            div <= div + 1'b1;
          end
        end
        S_STOP: begin
          // bit_cnt is reused here to count stop bits.
          if (div_wrap) begin
            div <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (start_ok) begin
                state       <= S_POP;
                fifo_rd_ena <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
            // Raise the pulse one cycle early so it lands on the final cycle.
            if (div == DIV_PENULT && bit_cnt == STOP_LAST) begin
              frame_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Testbench for fifo_serial_tx. Two instances share clock, reset and
// tx_enable: instance 0 uses the default frame format, instance 1 adds even
// parity and two stop bits. Each has its own FIFO model. A frame-level
// reference model predicts, for every cycle, the line value, read strobe,
// busy and frame_done from the word being sent.
module tb_fifo_serial_tx;

  localparam int W   = 4;
  localparam int CPB = 4;

  logic         clk;
  logic         rst;
  logic         tx_enable;
  logic         fifo_empty   [2];
  logic [W-1:0] fifo_rd_data [2];
  logic         fifo_rd_ena  [2];
  logic         txl          [2];
  logic         busy         [2];
  logic         frame_done   [2];

  fifo_serial_tx #(
    .FIFO_WIDTH  (W),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (0),
    .STOP_BITS   (1)
  ) dut0 (
    .clk         (clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .fifo_empty  (fifo_empty[0]),
    .fifo_rd_data(fifo_rd_data[0]),
    .fifo_rd_ena (fifo_rd_ena[0]),
    .tx          (txl[0]),
    .busy        (busy[0]),
    .frame_done  (frame_done[0])
  );

  fifo_serial_tx #(
    .FIFO_WIDTH  (W),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (1),
    .STOP_BITS   (2)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .fifo_empty  (fifo_empty[1]),
    .fifo_rd_data(fifo_rd_data[1]),
    .fifo_rd_ena (fifo_rd_ena[1]),
    .tx          (txl[1]),
    .busy        (busy[1]),
    .frame_done  (frame_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // FIFO contents seen by each DUT, and the model's copy of pushed words.
  logic [W-1:0] fq0[$];
  logic [W-1:0] fq1[$];
  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];

  // Model: pos = -1 when idle, else cycles since the pop cycle.
  int           pos   [2];
  logic [W-1:0] mword [2];
  int           npop  [2];
  int           flen  [2];
  int           pen   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic exp_tx(input int i);
    int b;
    if (pos[i] < 2) return 1'b1;
    b = (pos[i] - 2) / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return mword[i][b-1];
    if (pen[i] != 0 && b == W + 1) return ^mword[i];
    return 1'b1;
  endfunction

  task automatic push(input int i, input logic [W-1:0] w);
    if (i == 0) begin
      fq0.push_back(w);
      mq0.push_back(w);
      fifo_empty[0] = 1'b0;
    end else begin
      fq1.push_back(w);
      mq1.push_back(w);
      fifo_empty[1] = 1'b0;
    end
  endtask

  task automatic step();
    logic pr, pe;
    logic pem [2];
    logic prd [2];
    pr = rst;
    pe = tx_enable;
    for (int i = 0; i < 2; i++) begin
      pem[i] = fifo_empty[i];
      prd[i] = fifo_rd_ena[i];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      // FIFO model: one-cycle read latency.
      if (prd[i] === 1'b1) begin
        npop[i]++;
        if (i == 0 && fq0.size() > 0) fifo_rd_data[0] = fq0.pop_front();
        if (i == 1 && fq1.size() > 0) fifo_rd_data[1] = fq1.pop_front();
      end
      fifo_empty[i] = (i == 0) ? (fq0.size() == 0) : (fq1.size() == 0);
      // Frame-level reference.
      if (pr) pos[i] = -1;
      else if (pos[i] < 0 || pos[i] == 1 + flen[i]) pos[i] = (pe && !pem[i]) ? 0 : -1;
      else pos[i]++;
      if (pos[i] == 0) begin
        if (i == 0 && mq0.size() > 0) mword[0] = mq0.pop_front();
        if (i == 1 && mq1.size() > 0) mword[1] = mq1.pop_front();
      end
      check($sformatf("tx%0d@%0d", i, cyc), 32'(txl[i]), 32'(exp_tx(i)));
      check($sformatf("rd_ena%0d@%0d", i, cyc), 32'(fifo_rd_ena[i]), 32'(pos[i] == 0));
      check($sformatf("busy%0d@%0d", i, cyc), 32'(busy[i]), 32'(pos[i] >= 0));
      check($sformatf("frame_done%0d@%0d", i, cyc), 32'(frame_done[i]),
            32'(pos[i] == 1 + flen[i]));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 600 && !(pos[0] < 0 && pos[1] < 0 &&
           (!tx_enable || (fq0.size() == 0 && fq1.size() == 0)))) begin
      step();
      k++;
    end
    check("drain_bound", 32'(k < 600), 32'd1);
    run(3);
  endtask

  initial begin
    int p0, p1;
    pos[0] = -1;  pos[1] = -1;
    npop[0] = 0;  npop[1] = 0;
    pen[0] = 0;   pen[1] = 1;
    flen[0] = (1 + W + 0 + 1) * CPB;
    flen[1] = (1 + W + 1 + 2) * CPB;
    mword[0] = '0; mword[1] = '0;
    fifo_rd_data[0] = '0; fifo_rd_data[1] = '0;
    fifo_empty[0] = 1'b1; fifo_empty[1] = 1'b1;
    rst = 1'b1;
    tx_enable = 1'b1;

    // Reset then idle with an empty FIFO.
    run(2);
    rst = 1'b0;
    run(100);
    check("idle_no_pop0", 32'(npop[0]), 32'd0);
    check("idle_no_pop1", 32'(npop[1]), 32'd0);

    // Single frames: 0xA on the plain line, 0x7 (parity 1) on the parity line.
    push(0, 4'hA);
    push(1, 4'h7);
    drain();
    check("single_pop0", 32'(npop[0]), 32'd1);
    check("single_pop1", 32'(npop[1]), 32'd1);

    // Back-to-back pairs; 0x5 gives parity 0.
    push(0, 4'h3); push(0, 4'hC);
    push(1, 4'h5); push(1, 4'h3);
    drain();
    check("b2b_pop0", 32'(npop[0]), 32'd3);
    check("b2b_pop1", 32'(npop[1]), 32'd3);
    check("b2b_empty0", 32'(fifo_empty[0]), 32'd1);

    // Drop tx_enable during DATA of the first of two queued words.
    push(0, 4'h9); push(0, 4'h6);
    push(1, 4'h9); push(1, 4'h6);
    run(10);
    tx_enable = 1'b0;
    run(60);
    check("drop_left0", 32'(fq0.size()), 32'd1);
    check("drop_left1", 32'(fq1.size()), 32'd1);
    check("drop_busy0", 32'(busy[0]), 32'd0);
    tx_enable = 1'b1;
    drain();
    check("resume_empty0", 32'(fq0.size()), 32'd0);
    check("resume_pop0", 32'(npop[0]), 32'd5);

    // Reset during data bit 2 of instance 0.
    push(0, 4'hB);
    push(1, 4'hB);
    run(15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_tx0", 32'(txl[0]), 32'd1);
    check("rst_busy0", 32'(busy[0]), 32'd0);
    p0 = npop[0];
    p1 = npop[1];
    run(20);
    check("rst_no_repop0", 32'(npop[0]), 32'(p0));
    check("rst_no_repop1", 32'(npop[1]), 32'(p1));

    // Randomised traffic with enable toggling and rare resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0 && fq0.size() < 4) push(0, W'($urandom));
      if ($urandom_range(7) == 0 && fq1.size() < 4) push(1, W'($urandom));
      if ($urandom_range(39) == 0) tx_enable = ~tx_enable;
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0;
    tx_enable = 1'b1;
    drain();
    check("final_empty0", 32'(fq0.size()), 32'd0);
    check("final_empty1", 32'(fq1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
